reg_write_dispatcher: RTL and testbench



---
 rtl/reg_write_dispatcher.sv | 213 +++++++++++++++++++++
 tb/tb_reg_write_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_dispatcher
//  Description : Buffers serial frames in a small FIFO, splits each into an
//                address/data pair and presents it to the configuration
//                register targets with a one-hot select. Each write waits for
//                ack; on timeout it is re-presented up to MAX_RETRY times,
//                then abandoned with a one-cycle drop pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_dispatcher #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8,
    parameter int MAX_RETRY  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W+DATA_W-1:0]    frame,
    input  logic                        frame_valid,
    output logic                        frame_ready,
    output logic                        overflow,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           data,
    output logic [(2**ADDR_W)-1:0]      sel,
    output logic                        valid,
    input  logic                        ack,
    output logic                        drop,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int NUM_TGT = 2**ADDR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic               full_w;
    logic               empty_w;
    logic               push_w;
    logic               pop_w;
    logic [FRAME_W-1:0] head_w;

    assign full_w  = (level_q == LVL_FULL);
    assign empty_w = (level_q == '0);
    assign push_w  = frame_valid && !full_w;
    assign head_w  = mem_q[rd_ptr_q];

    // Occupancy bookkeeping; a push while full is never accepted, so a
    // simultaneous push/pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_w, pop_w})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset discards all buffered frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Frame storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_ptr_q] <= frame;
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                redo_q, redo_d;
    logic                drop_q, drop_d;

    // FSM and write-bus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            retry_q <= '0;
            redo_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            redo_q  <= redo_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: pop in IDLE, hold in SEND until ack or timeout,
    // one idle GAP cycle before either a retry or returning to IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        redo_d  = redo_q;
        drop_d  = 1'b0;
        pop_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    addr_d  = head_w[FRAME_W-1:DATA_W];
                    data_d  = head_w[DATA_W-1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    retry_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ack) begin
                    // ack takes priority over a coincident timeout
                    valid_d = 1'b0;
                    redo_d  = 1'b0;
                    state_d = GAP;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        redo_d  = 1'b1;
                    end else begin
                        redo_d  = 1'b0;
                        drop_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (redo_q) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // One-hot target select, forced to zero whenever no write is presented.
    always_comb begin
        sel = '0;
        if (valid_q) sel[addr_q] = 1'b1;
    end

    assign address     = addr_q;
    assign data        = data_q;
    assign valid       = valid_q;
    assign drop        = drop_q;
    assign level       = level_q;
    assign frame_ready = !full_w;
    assign overflow    = frame_valid && full_w;
    assign busy        = (state_q != IDLE) || !empty_w;

    // NUM_TGT documents the select width; referenced here to keep it live.
    logic unused_w;
    assign unused_w = (NUM_TGT == 0);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_dispatcher
//  Description : Scoreboard bench for reg_write_dispatcher. Stimulus pushes
//                expected write completions / drops and burst lengths; a
//                negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_dispatcher;

    logic        clk;
    logic        rst;
    logic [7:0]  frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        overflow;
    logic [3:0]  address;
    logic [3:0]  data;
    logic [15:0] sel;
    logic        valid;
    logic        ack;
    logic        drop;
    logic        busy;
    logic [2:0]  level;

    reg_write_dispatcher #(
        .ADDR_W     (4),
        .DATA_W     (4),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8),
        .MAX_RETRY  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow),
        .address     (address),
        .data        (data),
        .sel         (sel),
        .valid       (valid),
        .ack         (ack),
        .drop        (drop),
        .busy        (busy),
        .level       (level)
    );

    typedef struct packed {
        logic        is_drop;
        logic [3:0]  addr;
        logic [3:0]  dat;
        logic [15:0] sel;
    } ev_t;

    ev_t sb[$];
    int  exp_burst[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    bit  burst_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares every completed or dropped write, and every
    // valid burst length, against the scoreboard queues.
    initial begin : monitor
        ev_t e;
        int  run_len;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
            end else begin
                if ((valid && ack) || drop) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_miss++;
                        $display("FAIL event_unexpected: got drop=%0b addr=%h data=%h sel=%h, required no event",
                                 drop, address, data, sel);
                    end else begin
                        e = sb.pop_front();
                        if (drop !== e.is_drop || address !== e.addr || data !== e.dat || sel !== e.sel) begin
                            n_miss++;
                            $display("FAIL event: got drop=%0b addr=%h data=%h sel=%h, required drop=%0b addr=%h data=%h sel=%h",
                                     drop, address, data, sel, e.is_drop, e.addr, e.dat, e.sel);
                        end
                    end
                end
                if (valid) begin
                    run_len++;
                end else if (run_len > 0) begin
                    if (burst_en) begin
                        n_vec++;
                        if (exp_burst.size() == 0) begin
                            n_miss++;
                            $display("FAIL burst_unexpected: got length %0d, required none", run_len);
                        end else if (run_len != exp_burst[0]) begin
                            n_miss++;
                            $display("FAIL burst_len: got %0d, required %0d", run_len, exp_burst[0]);
                            void'(exp_burst.pop_front());
                        end else begin
                            void'(exp_burst.pop_front());
                        end
                    end
                    run_len = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] sel4 [5];
        logic [2:0]  lvl5 [6];
        logic [27:0] got_v, got_d, got_b, exp_v, exp_d, exp_b;
        bit          seen_hi, seen_fall, retry_seen, bad;

        sel4 = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020};
        lvl5 = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

        rst = 1'b1; frame = 8'h00; frame_valid = 1'b0; ack = 1'b0;
        tick(); tick();
        // Reset state
        chk("rst_addr_data", {address, data}, 8'h00);
        chk("rst_valid_sel", {valid, sel}, 17'h0);
        chk("rst_drop_ovf",  {drop, overflow}, 2'b00);
        chk("rst_ready",     frame_ready, 1'b1);
        chk("rst_level_busy", {level, busy}, 4'h0);
        rst = 1'b0;
        tick();

        // Test 1: 8'hA5 acked on third valid cycle
        sb.push_back('{1'b0, 4'hA, 4'h5, 16'h0400});
        exp_burst.push_back(3);
        frame = 8'hA5; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("t1_lat_edgeN", valid, 1'b0);
        tick();
        chk("t1_lat_edgeN1", valid, 1'b1);
        tick(); tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_valid_low", valid, 1'b0);
        tick(); tick(); tick();

        // Test 2: 8'h3C never acked -> 3 bursts of 8, then drop
        sb.push_back('{1'b1, 4'h3, 4'hC, 16'h0000});
        exp_burst.push_back(8); exp_burst.push_back(8); exp_burst.push_back(8);
        frame = 8'h3C; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            got_v[k-1] = valid;
            got_d[k-1] = drop;
            got_b[k-1] = busy;
            exp_v[k-1] = (k <= 26) && (k % 9 != 0);
            exp_d[k-1] = (k == 27);
            exp_b[k-1] = (k <= 27);
        end
        chk("t2_valid_pattern", 32'(got_v), 32'(exp_v));
        chk("t2_drop_pattern",  32'(got_d), 32'(exp_d));
        chk("t2_busy_pattern",  32'(got_b), 32'(exp_b));
        tick(); tick();

        // Test 3: ack coincides with count==7 -> completes, no retry
        sb.push_back('{1'b0, 4'hF, 4'h0, 16'h8000});
        exp_burst.push_back(8);
        frame = 8'hF0; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        for (int k = 2; k <= 8; k++) tick();
        chk("t3_valid_c8", valid, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (valid || drop) bad = 1'b1;
            tick();
        end
        chk("t3_no_retry", bad, 1'b0);

        // Test 4: five frames back to back, ack tied high
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{1'b0, 4'(i + 1), 4'(i + 1), sel4[i]});
            exp_burst.push_back(1);
        end
        for (int i = 0; i < 5; i++) begin
            frame = {4'(i + 1), 4'(i + 1)};
            frame_valid = 1'b1;
            chk($sformatf("t4_ready_%0d", i), frame_ready, 1'b1);
            tick();
        end
        frame_valid = 1'b0;
        wait_drain("t4_drain", 200);
        tick(); tick(); tick(); tick();
        ack = 1'b0;
        chk("t4_burst_q_empty", 32'(exp_burst.size()), 32'd0);

        // Test 5: ack low, six frames -> FIFO fills, one overflow
        burst_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            frame = 8'h81 + 8'(i);
            frame_valid = 1'b1;
            #1;
            chk($sformatf("t5_level_%0d", i), level, lvl5[i]);
            chk($sformatf("t5_ovf_%0d", i), overflow, (i == 5));
            chk($sformatf("t5_ready_%0d", i), frame_ready, (i != 5));
            tick();
        end
        frame_valid = 1'b0;
        #1;
        chk("t5_level_full", {level, frame_ready, overflow}, {3'd4, 1'b0, 1'b0});
        rst = 1'b1;
        #1;
        chk("t5_rst_level", {level, valid, frame_ready}, {3'd0, 1'b0, 1'b1});
        tick();
        rst = 1'b0;
        tick();

        // Test 6: reset during a retry of 8'h7E with two frames queued
        frame = 8'h7E; frame_valid = 1'b1;
        tick();
        frame = 8'h01;
        tick();
        frame = 8'h02;
        tick();
        frame_valid = 1'b0;
        seen_hi = 1'b0; seen_fall = 1'b0; retry_seen = 1'b0;
        for (int k = 0; k < 40 && !retry_seen; k++) begin
            if (valid && seen_fall) retry_seen = 1'b1;
            else if (valid) seen_hi = 1'b1;
            else if (seen_hi) seen_fall = 1'b1;
            if (!retry_seen) tick();
        end
        chk("t6_retry_reached", retry_seen, 1'b1);
        tick(); tick();
        chk("t6_pre_rst", {address, data, level, valid}, {4'h7, 4'hE, 3'd2, 1'b1});
        rst = 1'b1;
        #1;
        chk("t6_rst_valid_sel", {valid, sel}, 17'h0);
        chk("t6_rst_level_addr", {level, address, drop}, {3'd0, 4'h0, 1'b0});
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid || busy || drop || level != 3'd0) bad = 1'b1;
        end
        chk("t6_no_write_after_rst", bad, 1'b0);

        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_burst_empty", 32'(exp_burst.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
